// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
//  Module      : arb_requester
//  Description : Requester side of a two-wire request/grant arbitration
//                handshake. Local logic queues bus-tenure jobs (burst
//                lengths) into a small FIFO. Each job is played out as:
//                raise request, wait for grant, own the bus for the job
//                length, release, then wait for grant to drop. Grant-wait
//                timeouts and illegal arbiter behaviour are reported through
//                sticky error flags.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH  job queue entries (power of two, >= 2)
//    LEN_W       width of the job length field
//    TIMEOUT     cycles waited in REQ without grant before abort (1..255)
//  Ports
//    clk          in   clock, rising edge
//    reset        in   synchronous active-high reset
//    job_valid    in   job offered by local logic
//    job_len      in   tenure length in cycles (0 behaves as 1)
//    job_ready    out  queue can accept a job (not full)
//    request      out  registered request to the arbiter
//    grant        in   grant from the arbiter
//    bus_active   out  high exactly during owned cycles
//    done         out  one-cycle pulse on normal job completion
//    timeout_err  out  sticky: grant wait exceeded TIMEOUT
//    proto_err    out  sticky: illegal grant behaviour seen
//    err_clr      in   clears both sticky error flags
//    job_cnt      out  completed job count, saturates at 255
// ============================================================================
module arb_requester #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             request,
  input  logic             grant,
  output logic             bus_active,
  output logic             done,
  output logic             timeout_err,
  output logic             proto_err,
  input  logic             err_clr,
  output logic [7:0]       job_cnt
);

  localparam int             AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_CNT    = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]     TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OWN  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Job FIFO
  // --------------------------------------------------------------------------
  logic [LEN_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic [LEN_W-1:0] head_len;
  logic             push;
  logic             pop;

  assign job_ready = (fifo_cnt != FULL_CNT);
  assign push      = job_valid && job_ready;
  assign head_len  = fifo_mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= job_len;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Tenure state machine
  // --------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic             request_nxt;
  logic             bus_active_nxt;
  logic             done_nxt;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] len_cnt_nxt;
  logic [7:0]       wait_cnt;
  logic [7:0]       wait_cnt_nxt;
  logic             timeout_set;
  logic             proto_set;
  logic             cnt_inc;

  always_comb begin
    state_nxt      = state;
    request_nxt    = request;
    bus_active_nxt = bus_active;
    done_nxt       = 1'b0;
    len_cnt_nxt    = len_cnt;
    wait_cnt_nxt   = wait_cnt;
    pop            = 1'b0;
    timeout_set    = 1'b0;
    proto_set      = 1'b0;
    cnt_inc        = 1'b0;

    case (state)
      S_IDLE: begin
        // The arbiter must never grant a port that is not requesting.
        if (grant) begin
          proto_set = 1'b1;
        end
        if (fifo_cnt != '0) begin
          pop          = 1'b1;
          len_cnt_nxt  = (head_len == '0) ? LEN_ONE : head_len;
          wait_cnt_nxt = '0;
          request_nxt  = 1'b1;
          state_nxt    = S_REQ;
        end
      end

      S_REQ: begin
        if (grant) begin
          bus_active_nxt = 1'b1;
          state_nxt      = S_OWN;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          // Abort: the job is dropped without done or a count update.
          timeout_set = 1'b1;
          request_nxt = 1'b0;
          state_nxt   = S_REL;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end

      S_OWN: begin
        // The final owned cycle completes normally whatever grant does.
        if (len_cnt == LEN_ONE) begin
          request_nxt    = 1'b0;
          bus_active_nxt = 1'b0;
          done_nxt       = 1'b1;
          cnt_inc        = 1'b1;
          state_nxt      = S_REL;
        end else if (!grant) begin
          proto_set      = 1'b1;
          request_nxt    = 1'b0;
          bus_active_nxt = 1'b0;
          state_nxt      = S_REL;
        end else begin
          len_cnt_nxt = len_cnt - LEN_ONE;
        end
      end

      S_REL: begin
        // At least one cycle here keeps request low >= 2 cycles between jobs.
        if (!grant) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      request     <= 1'b0;
      bus_active  <= 1'b0;
      done        <= 1'b0;
      len_cnt     <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      job_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      request    <= request_nxt;
      bus_active <= bus_active_nxt;
      done       <= done_nxt;
      len_cnt    <= len_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;

      // A new error event takes priority over a simultaneous clear.
      if (timeout_set) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end

      if (proto_set) begin
        proto_err <= 1'b1;
      end else if (err_clr) begin
        proto_err <= 1'b0;
      end

      if (cnt_inc && (job_cnt != 8'hFF)) begin
        job_cnt <= job_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_requester
//  Description : Self-checking bench for arb_requester. A stimulus process
//                queues jobs together with the arbiter behaviour to apply to
//                each one; a behavioural arbiter plays that behaviour back;
//                a monitor measures each tenure and compares it against the
//                expected outcome taken from a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_requester;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 4;
  localparam int TIMEOUT    = 15;

  localparam int K_DONE  = 0;   // arbiter grants and holds until release
  localparam int K_TMO   = 1;   // arbiter never grants
  localparam int K_PROTO = 2;   // arbiter drops grant after 'drop' owned cycles

  typedef struct {
    int kind;
    int len;    // effective tenure length (0 already mapped to 1)
    int dly;    // grant delay in cycles after request is seen
    int rel;    // grant release delay after request drops
    int drop;   // owned cycles before grant is pulled (K_PROTO)
  } job_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             request;
  logic             grant;
  logic             bus_active;
  logic             done;
  logic             timeout_err;
  logic             proto_err;
  logic             err_clr;
  logic [7:0]       job_cnt;

  logic arb_en;
  logic arb_grant;
  logic man_grant;
  logic mon_en;

  assign grant = arb_en ? arb_grant : man_grant;

  job_t mode_q[$];
  job_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int stray_done = 0;
  int bus_no_req = 0;

  arb_requester #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .job_valid   (job_valid),
    .job_len     (job_len),
    .job_ready   (job_ready),
    .request     (request),
    .grant       (grant),
    .bus_active  (bus_active),
    .done        (done),
    .timeout_err (timeout_err),
    .proto_err   (proto_err),
    .err_clr     (err_clr),
    .job_cnt     (job_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Queue a job plus the arbiter behaviour and expected outcome for it.
  task automatic push_job(input int len, input int kind, input int dly,
                          input int rel, input int drop);
    job_t j;
    int   n;
    j.kind = kind;
    j.len  = (len == 0) ? 1 : len;
    j.dly  = dly;
    j.rel  = rel;
    j.drop = drop;
    n = 0;
    while (!job_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) begin
      chk("push_ready_wait", 0, 1);
    end else begin
      mode_q.push_back(j);
      exp_q.push_back(j);
      job_valid = 1'b1;
      job_len   = len[LEN_W-1:0];
      @(negedge clk);
      job_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || request || arb_grant) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || request || arb_grant) chk("idle_wait", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural arbiter
  // --------------------------------------------------------------------------
  initial begin
    job_t m;
    int   n;
    int   c;
    arb_grant = 1'b0;
    forever begin
      @(negedge clk);
      if (!arb_en) begin
        arb_grant = 1'b0;
      end else if (request && !arb_grant) begin
        if (mode_q.size() == 0) begin
          chk("arb_mode_avail", 0, 1);
          m.kind = K_TMO; m.len = 1; m.dly = 0; m.rel = 0; m.drop = 0;
        end else begin
          m = mode_q.pop_front();
        end
        if (m.kind != K_TMO) begin
          repeat (m.dly) @(negedge clk);
          arb_grant = 1'b1;
        end
        if (m.kind == K_PROTO) begin
          n = 0;
          c = 0;
          while (c < m.drop && n < 500) begin
            @(negedge clk);
            n++;
            if (bus_active) c++;
          end
          arb_grant = 1'b0;
        end
        n = 0;
        while (request && n < 500) begin
          @(negedge clk);
          n++;
        end
        if (request) chk("arb_req_drop_wait", 0, 1);
        if (m.kind == K_DONE) begin
          repeat (m.rel) @(negedge clk);
          arb_grant = 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin
    job_t e;
    int   req_run;
    int   bus_run;
    int   low_run;
    int   exp_cnt;
    bit   prev_req;
    bit   had_job;
    bit   clr_pending;
    err_clr = 1'b0;
    req_run = 0; bus_run = 0; low_run = 0; exp_cnt = 0;
    prev_req = 1'b0; had_job = 1'b0; clr_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_pending) begin
        err_clr     = 1'b0;
        clr_pending = 1'b0;
        chk("err_clr_timeout", timeout_err, 0);
        chk("err_clr_proto", proto_err, 0);
      end
      if (!mon_en) begin
        prev_req = request;
        continue;
      end
      if (done && !(prev_req && !request)) stray_done++;
      if (request) begin
        if (!prev_req) begin
          if (had_job) chk("req_low_gap_ge2", (low_run >= 2), 1);
          req_run = 0;
          bus_run = 0;
        end
        req_run++;
        if (bus_active) bus_run++;
        low_run = 0;
      end else begin
        if (bus_active) bus_no_req++;
        if (prev_req) begin
          had_job = 1'b1;
          if (exp_q.size() == 0) begin
            chk("exp_avail", 0, 1);
          end else begin
            e = exp_q.pop_front();
            if (e.kind == K_DONE) begin
              exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
              chk("done_pulse", done, 1);
              chk("tenure_len", bus_run, e.len);
              chk("job_cnt", job_cnt, exp_cnt);
              chk("done_no_err", {timeout_err, proto_err}, 0);
            end else if (e.kind == K_TMO) begin
              chk("tmo_no_done", done, 0);
              chk("timeout_err", timeout_err, 1);
              chk("tmo_req_cycles", req_run, TIMEOUT + 1);
              chk("tmo_no_bus", bus_run, 0);
              chk("tmo_job_cnt", job_cnt, exp_cnt);
              err_clr     = 1'b1;
              clr_pending = 1'b1;
            end else begin
              chk("proto_no_done", done, 0);
              chk("proto_err", proto_err, 1);
              chk("proto_tenure", bus_run, e.drop);
              chk("proto_job_cnt", job_cnt, exp_cnt);
              err_clr     = 1'b1;
              clr_pending = 1'b1;
            end
          end
        end
        low_run++;
      end
      prev_req = request;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int n;
    int seen;
    reset     = 1'b1;
    job_valid = 1'b0;
    job_len   = '0;
    arb_en    = 1'b1;
    man_grant = 1'b0;
    mon_en    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_request", request, 0);
    chk("rst_bus_active", bus_active, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_job_cnt", job_cnt, 0);
    chk("rst_job_ready", job_ready, 1);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single job, grant one cycle after request; four more fill the queue
    // while it is still being served.
    push_job(3, K_DONE, 1, 1, 0);
    chk("req_not_yet", request, 0);
    @(negedge clk);
    chk("req_rise", request, 1);
    push_job(2, K_DONE, 1, 1, 0);
    push_job(1, K_DONE, 0, 0, 0);
    push_job(4, K_DONE, 2, 1, 0);
    push_job(0, K_DONE, 1, 2, 0);
    chk("job_ready_full", job_ready, 0);
    wait_idle();

    // Timeout, then a normal job, then early grant loss.
    push_job(2, K_TMO, 0, 0, 0);
    push_job(1, K_DONE, 0, 0, 0);
    push_job(5, K_PROTO, 1, 0, 1);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      int len;
      int leff;
      int r;
      int kind;
      int drop;
      len  = $urandom_range(0, 15);
      leff = (len == 0) ? 1 : len;
      r    = $urandom_range(0, 9);
      kind = (r < 6) ? K_DONE : ((r < 8) ? K_TMO : K_PROTO);
      if (kind == K_PROTO && leff < 2) kind = K_DONE;
      drop = (kind == K_PROTO) ? $urandom_range(1, leff - 1) : 0;
      push_job(len, kind, $urandom_range(0, 3), $urandom_range(0, 2), drop);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_idle();
    chk("stray_done", stray_done, 0);
    chk("bus_without_request", bus_no_req, 0);
    chk("mode_q_drained", mode_q.size(), 0);

    // Directed: spurious grant while idle and empty.
    mon_en = 1'b0;
    arb_en = 1'b0;
    @(negedge clk);
    man_grant = 1'b1;
    @(negedge clk);
    man_grant = 1'b0;
    chk("spurious_proto_err", proto_err, 1);
    chk("spurious_no_request", request, 0);
    @(negedge clk);
    chk("spurious_request_stays_low", request, 0);

    // Directed: reset in the third owned cycle of a len=8 job, with a second
    // job waiting in the queue.
    job_valid = 1'b1;
    job_len   = 4'd8;
    @(negedge clk);
    job_len   = 4'd3;
    @(negedge clk);
    job_valid = 1'b0;
    chk("mid_own_req", request, 1);
    man_grant = 1'b1;
    n = 0;
    seen = 0;
    while (seen < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (bus_active) seen++;
    end
    chk("mid_own_reach_cycle3", seen, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_request", request, 0);
    chk("mid_rst_bus_active", bus_active, 0);
    chk("mid_rst_job_cnt", job_cnt, 0);
    chk("mid_rst_errors", {timeout_err, proto_err}, 0);
    chk("mid_rst_job_ready", job_ready, 1);
    reset     = 1'b0;
    man_grant = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (request) seen++;
    end
    chk("mid_rst_fifo_flushed", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
